// File: rtl/ga23_tile_fetch_arb.sv
// ga23_tile_fetch_arb: round-robin arbiter that collects tile-row fetch
// requests from the background layers, issues them one at a time to the
// SDRAM tile-ROM port, and returns each 32-bit row to the layer that asked.
module ga23_tile_fetch_arb #(
  parameter int          NUM_LAYERS = 3,
  parameter logic [23:0] ROM_BASE   = 24'h000000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_LAYERS-1:0]    layer_req,
  input  logic [21*NUM_LAYERS-1:0] layer_addr,
  output logic [32*NUM_LAYERS-1:0] layer_data,
  output logic [NUM_LAYERS-1:0]    layer_rdy,
  output logic                     mem_req,
  output logic [23:0]              mem_addr,
  input  logic                     mem_ack,
  input  logic                     mem_rdy,
  input  logic [31:0]              mem_data,
  output logic [NUM_LAYERS-1:0]    overrun
);

  localparam int GW  = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int GW1 = GW + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_DELIVER = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [NUM_LAYERS-1:0]     pend_q, pend_d;
  logic [20:0]               paddr_q [NUM_LAYERS];
  logic [20:0]               paddr_d [NUM_LAYERS];
  logic [GW-1:0]             rr_q, rr_d;
  logic [GW-1:0]             gnt_q, gnt_d;
  logic [NUM_LAYERS-1:0]     ovr_q, ovr_d;
  logic [NUM_LAYERS-1:0]     rdy_q, rdy_d;
  logic [32*NUM_LAYERS-1:0]  ldata_q, ldata_d;
  logic                      mreq_q, mreq_d;
  logic [23:0]               maddr_q, maddr_d;
  logic [31:0]               word_q, word_d;

  logic                      sel_vld;
  logic [GW-1:0]             sel_idx;
  logic [GW1-1:0]            sel_sum;
  logic [GW-1:0]             sel_pos;
  logic                      grant;

  // Pick the first pending layer at or after the round-robin pointer;
  // scanning downwards lets the lowest offset from rr win.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    sel_sum = '0;
    sel_pos = '0;
    for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
      sel_sum = {1'b0, rr_q} + GW1'(k);
      if (sel_sum >= GW1'(NUM_LAYERS)) begin
        sel_sum = sel_sum - GW1'(NUM_LAYERS);
      end
      sel_pos = sel_sum[GW-1:0];
      if (pend_q[sel_pos]) begin
        sel_vld = 1'b1;
        sel_idx = sel_pos;
      end
    end
  end

  assign grant = (state_q == S_IDLE) && sel_vld;

  // Next-state logic: pending slots, grant, memory handshake and delivery.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    paddr_d = paddr_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    ovr_d   = ovr_q;
    rdy_d   = '0;
    ldata_d = ldata_q;
    mreq_d  = mreq_q;
    maddr_d = maddr_q;
    word_d  = word_q;

    // Grant clears the slot first so a same-cycle request re-arms it cleanly.
    if (grant) begin
      pend_d[sel_idx] = 1'b0;
      maddr_d         = ROM_BASE + {3'b000, paddr_q[sel_idx]};
      mreq_d          = 1'b1;
      rr_d            = (sel_idx == GW'(NUM_LAYERS - 1)) ? '0 : sel_idx + 1'b1;
      gnt_d           = sel_idx;
      state_d         = S_ISSUE;
    end

    // A request over a still-pending slot replaces its address and flags it.
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (layer_req[i]) begin
        if (pend_q[i] && !(grant && (sel_idx == GW'(i)))) begin
          ovr_d[i] = 1'b1;
        end
        pend_d[i]  = 1'b1;
        paddr_d[i] = layer_addr[21*i +: 21];
      end
    end

    case (state_q)
      S_ISSUE: begin
        if (mem_ack) begin
          mreq_d = 1'b0;
          if (mem_rdy) begin
            word_d  = mem_data;
            state_d = S_DELIVER;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (mem_rdy) begin
          word_d  = mem_data;
          state_d = S_DELIVER;
        end
      end
      S_DELIVER: begin
        for (int i = 0; i < NUM_LAYERS; i++) begin
          if (gnt_q == GW'(i)) begin
            ldata_d[32*i +: 32] = word_q;
            rdy_d[i]            = 1'b1;
          end
        end
        state_d = S_IDLE;
      end
      default: ;
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
        paddr_q[i] <= '0;
      end
      rr_q    <= '0;
      gnt_q   <= '0;
      ovr_q   <= '0;
      rdy_q   <= '0;
      ldata_q <= '0;
      mreq_q  <= 1'b0;
      maddr_q <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      for (int i = 0; i < NUM_LAYERS; i++) begin
        paddr_q[i] <= paddr_d[i];
      end
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      ovr_q   <= ovr_d;
      rdy_q   <= rdy_d;
      ldata_q <= ldata_d;
      mreq_q  <= mreq_d;
      maddr_q <= maddr_d;
      word_q  <= word_d;
    end
  end

  assign layer_data = ldata_q;
  assign layer_rdy  = rdy_q;
  assign mem_req    = mreq_q;
  assign mem_addr   = maddr_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_ga23_tile_fetch_arb.sv
// Bench for ga23_tile_fetch_arb: directed scenarios plus randomized traffic,
// checked against a transaction-level reference model of the arbiter.
module tb_ga23_tile_fetch_arb;
  localparam int          NL   = 3;
  localparam logic [23:0] BASE = 24'h000000;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [NL-1:0]       layer_req;
  logic [21*NL-1:0]    layer_addr;
  logic [32*NL-1:0]    layer_data;
  logic [NL-1:0]       layer_rdy;
  logic                mem_req;
  logic [23:0]         mem_addr;
  logic                mem_ack;
  logic                mem_rdy;
  logic [31:0]         mem_data;
  logic [NL-1:0]       overrun;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ga23_tile_fetch_arb #(.NUM_LAYERS(NL), .ROM_BASE(BASE)) dut (
    .clk(clk), .reset_n(reset_n), .layer_req(layer_req), .layer_addr(layer_addr),
    .layer_data(layer_data), .layer_rdy(layer_rdy), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdy(mem_rdy),
    .mem_data(mem_data), .overrun(overrun)
  );

  // Reference model: pending slots, one outstanding transaction, timestamps.
  bit           m_pend [NL];
  logic [20:0]  m_addr [NL];
  int           m_rr, m_owner, m_deliver_at, m_edge;
  bit           m_busy, m_acked;
  logic [31:0]  m_word;
  logic         exp_req;
  logic [23:0]  exp_maddr;
  logic [NL-1:0] exp_rdy, exp_ovr;
  logic [32*NL-1:0] exp_data;

  // Memory responder knobs
  bit           auto_mem, use_fixed, stray;
  int           ack_lat, rdy_lat, r_cnt;
  bit           r_acked;
  logic [31:0]  fixed_word;

  function automatic void model_reset();
    for (int i = 0; i < NL; i++) begin
      m_pend[i] = 1'b0;
      m_addr[i] = '0;
    end
    m_rr = 0; m_owner = 0; m_deliver_at = 0; m_edge = 0;
    m_busy = 1'b0; m_acked = 1'b0; m_word = '0;
    exp_req = 1'b0; exp_maddr = '0; exp_rdy = '0; exp_ovr = '0; exp_data = '0;
    r_cnt = 0; r_acked = 1'b0;
  endfunction

  function automatic void model_edge();
    bit was_busy;
    int idx;
    was_busy = m_busy;
    m_edge++;
    exp_rdy = '0;
    if (was_busy) begin
      if (m_deliver_at == m_edge) begin
        for (int i = 0; i < NL; i++) begin
          if (i == m_owner) begin
            exp_data[32*i +: 32] = m_word;
            exp_rdy[i] = 1'b1;
          end
        end
        m_busy = 1'b0;
      end else if (!m_acked) begin
        if (mem_ack) begin
          m_acked = 1'b1;
          exp_req = 1'b0;
          if (mem_rdy) begin
            m_word = mem_data;
            m_deliver_at = m_edge + 1;
          end
        end
      end else if (m_deliver_at == 0 && mem_rdy) begin
        m_word = mem_data;
        m_deliver_at = m_edge + 1;
      end
    end else begin
      for (int k = 0; k < NL; k++) begin
        idx = (m_rr + k) % NL;
        if (!m_busy && m_pend[idx]) begin
          m_busy = 1'b1; m_acked = 1'b0; m_deliver_at = 0; m_owner = idx;
          m_pend[idx] = 1'b0;
          exp_req = 1'b1;
          exp_maddr = BASE + {3'b000, m_addr[idx]};
          m_rr = (idx + 1) % NL;
        end
      end
    end
    for (int i = 0; i < NL; i++) begin
      if (layer_req[i]) begin
        if (m_pend[i]) exp_ovr[i] = 1'b1;
        m_pend[i] = 1'b1;
        m_addr[i] = layer_addr[21*i +: 21];
      end
    end
  endfunction

  // One clock: drive the memory side, take the edge, update model, settle.
  task automatic step();
    if (auto_mem) begin
      mem_ack = 1'b0;
      mem_rdy = 1'b0;
      if (r_acked) begin
        r_cnt++;
        if (r_cnt >= rdy_lat) begin
          mem_rdy = 1'b1;
          mem_data = use_fixed ? fixed_word : $urandom;
          r_acked = 1'b0;
          r_cnt = 0;
        end
      end else if (mem_req) begin
        if (r_cnt >= ack_lat) begin
          mem_ack = 1'b1;
          r_cnt = 0;
          if (rdy_lat == 0) begin
            mem_rdy = 1'b1;
            mem_data = use_fixed ? fixed_word : $urandom;
          end else begin
            r_acked = 1'b1;
          end
        end else begin
          r_cnt++;
        end
      end else if (stray && $urandom_range(0, 3) == 0) begin
        mem_ack = 1'($urandom_range(0, 1));
        mem_rdy = 1'($urandom_range(0, 1));
        mem_data = $urandom;
      end
    end
    @(posedge clk);
    if (reset_n) model_edge();
    @(negedge clk);
    layer_req = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    layer_req = '0;
    mem_ack = 1'b0;
    mem_rdy = 1'b0;
    model_reset();
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_chk++;
    if ({mem_req, mem_addr, layer_rdy, layer_data, overrun} !== '0) begin
      $display("FAIL reset_state: got req=%b addr=%h rdy=%b data=%h ovr=%b, need all 0",
               mem_req, mem_addr, layer_rdy, layer_data, overrun);
    end else n_pass++;
    layer_req = 3'b111;
    step();
    model_reset();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++;
      if ({mem_req, layer_rdy, overrun} !== '0) begin
        $display("FAIL reset_ignores_req: got req=%b rdy=%b ovr=%b, need 0", mem_req, layer_rdy, overrun);
      end else n_pass++;
    end
  endtask

  task automatic test_single();
    int req_cycles;
    do_reset();
    ack_lat = 0; rdy_lat = 1; use_fixed = 1'b1; fixed_word = 32'hDEADBEEF;
    layer_addr = '0;
    layer_addr[41:21] = 21'h012345;
    layer_req = 3'b010;
    req_cycles = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      n_chk++;
      if ({mem_req, (exp_req ? mem_addr : 24'h0), layer_rdy, overrun, layer_data} !==
          {exp_req, (exp_req ? exp_maddr : 24'h0), exp_rdy, exp_ovr, exp_data}) begin
        $display("FAIL single_cyc%0d: got req=%b addr=%h rdy=%b ovr=%b data=%h need req=%b addr=%h rdy=%b ovr=%b data=%h",
                 i, mem_req, mem_addr, layer_rdy, overrun, layer_data, exp_req, exp_maddr, exp_rdy, exp_ovr, exp_data);
      end else n_pass++;
      if (mem_req) begin
        req_cycles++;
        n_chk++;
        if (mem_addr !== 24'h012345) $display("FAIL single_addr: got %h need 012345", mem_addr);
        else n_pass++;
      end
      if (i == 4) begin
        n_chk++;
        if (layer_rdy !== 3'b010) $display("FAIL single_latency: rdy at cycle 4 got %b need 010", layer_rdy);
        else n_pass++;
      end
    end
    n_chk++;
    if (req_cycles != 1) $display("FAIL single_req_len: got %0d cycles need 1", req_cycles);
    else n_pass++;
    n_chk++;
    if (layer_data !== {32'h0, 32'hDEADBEEF, 32'h0})
      $display("FAIL single_data: got %h need 00000000deadbeef00000000", layer_data);
    else n_pass++;
    use_fixed = 1'b0;
  endtask

  task automatic test_simultaneous();
    logic [71:0] aseq;
    logic [8:0]  rseq;
    int na, nr;
    logic prev;
    do_reset();
    ack_lat = 0; rdy_lat = 1;
    layer_addr = {21'd3, 21'd2, 21'd1};
    layer_req = 3'b111;
    aseq = '0; rseq = '0; na = 0; nr = 0; prev = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      n_chk++;
      if ({mem_req, (exp_req ? mem_addr : 24'h0), layer_rdy, overrun, layer_data} !==
          {exp_req, (exp_req ? exp_maddr : 24'h0), exp_rdy, exp_ovr, exp_data}) begin
        $display("FAIL simul_cyc%0d: got req=%b addr=%h rdy=%b ovr=%b need req=%b addr=%h rdy=%b ovr=%b",
                 i, mem_req, mem_addr, layer_rdy, overrun, exp_req, exp_maddr, exp_rdy, exp_ovr);
      end else n_pass++;
      if (mem_req && !prev) begin aseq = {aseq[47:0], mem_addr}; na++; end
      if (layer_rdy != 0) begin rseq = {rseq[5:0], layer_rdy}; nr++; end
      prev = mem_req;
    end
    n_chk++;
    if (na != 3 || aseq !== {24'd1, 24'd2, 24'd3}) $display("FAIL simul_addr_seq: got n=%0d %h need 3 000001000002000003", na, aseq);
    else n_pass++;
    n_chk++;
    if (nr != 3 || rseq !== 9'b001_010_100) $display("FAIL simul_rdy_order: got n=%0d %b need 3 001010100", nr, rseq);
    else n_pass++;
    n_chk++;
    if (overrun !== 3'b000) $display("FAIL simul_overrun: got %b need 000", overrun);
    else n_pass++;
  endtask

  task automatic test_fairness();
    logic [47:0] aseq;
    int na;
    logic prev;
    do_reset();
    ack_lat = 0; rdy_lat = 1;
    layer_addr = '0;
    layer_addr[20:0] = 21'h7;
    layer_req = 3'b001;
    for (int i = 0; i < 6; i++) step();
    layer_addr[20:0] = 21'h10;
    layer_addr[62:42] = 21'h20;
    layer_req = 3'b101;
    aseq = '0; na = 0; prev = 1'b0;
    for (int i = 0; i < 14; i++) begin
      step();
      n_chk++;
      if ({mem_req, (exp_req ? mem_addr : 24'h0), layer_rdy, overrun, layer_data} !==
          {exp_req, (exp_req ? exp_maddr : 24'h0), exp_rdy, exp_ovr, exp_data}) begin
        $display("FAIL fair_cyc%0d: got req=%b addr=%h rdy=%b need req=%b addr=%h rdy=%b",
                 i, mem_req, mem_addr, layer_rdy, exp_req, exp_maddr, exp_rdy);
      end else n_pass++;
      if (mem_req && !prev) begin aseq = {aseq[23:0], mem_addr}; na++; end
      prev = mem_req;
    end
    n_chk++;
    if (na != 2 || aseq !== {24'h20, 24'h10}) $display("FAIL fair_order: got n=%0d %h need 2 000020000010", na, aseq);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [47:0] aseq;
    int na, hold1;
    logic prev;
    logic [23:0] prev_addr;
    do_reset();
    ack_lat = 10; rdy_lat = 2;
    layer_addr = '0;
    layer_addr[41:21] = 21'h0ABCDE;
    layer_req = 3'b010;
    aseq = '0; na = 0; hold1 = 0; prev = 1'b0; prev_addr = '0;
    for (int i = 0; i < 45; i++) begin
      if (i == 3) begin
        layer_addr[20:0] = 21'h111;
        layer_req = 3'b001;
      end
      step();
      n_chk++;
      if ({mem_req, (exp_req ? mem_addr : 24'h0), layer_rdy, overrun, layer_data} !==
          {exp_req, (exp_req ? exp_maddr : 24'h0), exp_rdy, exp_ovr, exp_data}) begin
        $display("FAIL bp_cyc%0d: got req=%b addr=%h rdy=%b need req=%b addr=%h rdy=%b",
                 i, mem_req, mem_addr, layer_rdy, exp_req, exp_maddr, exp_rdy);
      end else n_pass++;
      if (mem_req && prev) begin
        n_chk++;
        if (mem_addr !== prev_addr) $display("FAIL bp_addr_stable: got %h need %h", mem_addr, prev_addr);
        else n_pass++;
      end
      if (mem_req && !prev) begin aseq = {aseq[23:0], mem_addr}; na++; end
      if (mem_req && na == 1) hold1++;
      prev = mem_req;
      prev_addr = mem_addr;
    end
    n_chk++;
    if (hold1 != 11) $display("FAIL bp_hold_len: got %0d cycles need 11", hold1);
    else n_pass++;
    n_chk++;
    if (na != 2 || aseq !== {24'h0ABCDE, 24'h000111}) $display("FAIL bp_order: got n=%0d %h need 2 0abcde000111", na, aseq);
    else n_pass++;
  endtask

  task automatic test_overrun();
    logic [71:0] aseq;
    int na;
    logic prev;
    do_reset();
    ack_lat = 0; rdy_lat = 3;
    layer_addr = '0;
    layer_addr[20:0] = 21'h1;
    layer_req = 3'b001;
    aseq = '0; na = 0; prev = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 2) begin layer_addr[62:42] = 21'h5; layer_req = 3'b100; end
      if (i == 4) begin layer_addr[62:42] = 21'h9; layer_req = 3'b100; end
      step();
      n_chk++;
      if ({mem_req, (exp_req ? mem_addr : 24'h0), layer_rdy, overrun, layer_data} !==
          {exp_req, (exp_req ? exp_maddr : 24'h0), exp_rdy, exp_ovr, exp_data}) begin
        $display("FAIL ovr_cyc%0d: got req=%b addr=%h rdy=%b ovr=%b need req=%b addr=%h rdy=%b ovr=%b",
                 i, mem_req, mem_addr, layer_rdy, overrun, exp_req, exp_maddr, exp_rdy, exp_ovr);
      end else n_pass++;
      if (mem_req && !prev) begin aseq = {aseq[47:0], mem_addr}; na++; end
      prev = mem_req;
    end
    n_chk++;
    if (na != 2 || aseq[47:0] !== {24'h1, 24'h9}) $display("FAIL ovr_fetches: got n=%0d %h need 2 000001000009", na, aseq[47:0]);
    else n_pass++;
    n_chk++;
    if (overrun !== 3'b100) $display("FAIL ovr_flag: got %b need 100", overrun);
    else n_pass++;
    // Re-request in the grant cycle of layer 1
    layer_addr[41:21] = 21'h33;
    layer_req = 3'b010;
    step();
    layer_addr[41:21] = 21'h44;
    layer_req = 3'b010;
    step();
    aseq = {48'h0, 24'h33}; na = 1; prev = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      n_chk++;
      if ({mem_req, (exp_req ? mem_addr : 24'h0), layer_rdy, overrun, layer_data} !==
          {exp_req, (exp_req ? exp_maddr : 24'h0), exp_rdy, exp_ovr, exp_data}) begin
        $display("FAIL ovr_grantcyc%0d: got req=%b addr=%h rdy=%b ovr=%b need req=%b addr=%h rdy=%b ovr=%b",
                 i, mem_req, mem_addr, layer_rdy, overrun, exp_req, exp_maddr, exp_rdy, exp_ovr);
      end else n_pass++;
      if (mem_req && !prev) begin aseq = {aseq[47:0], mem_addr}; na++; end
      prev = mem_req;
    end
    n_chk++;
    if (na != 2 || aseq[47:0] !== {24'h33, 24'h44}) $display("FAIL ovr_grant_refetch: got n=%0d %h need 2 000033000044", na, aseq[47:0]);
    else n_pass++;
    n_chk++;
    if (overrun !== 3'b100) $display("FAIL ovr_grant_noflag: got %b need 100", overrun);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    ack_lat = 0; rdy_lat = 100;
    layer_addr = '0;
    layer_addr[20:0] = 21'h77;
    layer_req = 3'b001;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin layer_addr[62:42] = 21'h55; layer_req = 3'b100; end
      step();
    end
    n_chk++;
    if (mem_req !== 1'b0 || exp_req !== 1'b0) $display("FAIL midrst_precond: req=%b, need 0 in wait", mem_req);
    else n_pass++;
    reset_n = 1'b0;
    #1;
    n_chk++;
    if ({mem_req, mem_addr, layer_rdy, layer_data, overrun} !== '0)
      $display("FAIL midrst_outputs: got req=%b addr=%h rdy=%b ovr=%b, need 0", mem_req, mem_addr, layer_rdy, overrun);
    else n_pass++;
    model_reset();
    @(negedge clk);
    step();
    reset_n = 1'b1;
    auto_mem = 1'b0;
    mem_rdy = 1'b1;
    mem_data = 32'hBAD0BAD0;
    step();
    mem_rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      n_chk++;
      if ({mem_req, layer_rdy, layer_data} !== '0)
        $display("FAIL midrst_stray_rdy%0d: got req=%b rdy=%b data=%h, need 0", i, mem_req, layer_rdy, layer_data);
      else n_pass++;
    end
    auto_mem = 1'b1;
  endtask

  task automatic test_random();
    logic [63:0] r;
    do_reset();
    stray = 1'b1;
    for (int rnd = 0; rnd < 4; rnd++) begin
      ack_lat = $urandom_range(0, 3);
      rdy_lat = $urandom_range(0, 3);
      for (int i = 0; i < 100; i++) begin
        if ($urandom_range(0, 2) == 0) begin
          r = {$urandom, $urandom};
          layer_addr = r[62:0];
          layer_req = 3'($urandom_range(1, 7));
        end
        step();
        n_chk++;
        if ({mem_req, (exp_req ? mem_addr : 24'h0), layer_rdy, overrun, layer_data} !==
            {exp_req, (exp_req ? exp_maddr : 24'h0), exp_rdy, exp_ovr, exp_data}) begin
          $display("FAIL rand_r%0d_c%0d: got req=%b addr=%h rdy=%b ovr=%b data=%h need req=%b addr=%h rdy=%b ovr=%b data=%h",
                   rnd, i, mem_req, mem_addr, layer_rdy, overrun, layer_data, exp_req, exp_maddr, exp_rdy, exp_ovr, exp_data);
        end else n_pass++;
      end
    end
    stray = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    layer_req = '0;
    layer_addr = '0;
    mem_ack = 1'b0;
    mem_rdy = 1'b0;
    mem_data = '0;
    auto_mem = 1'b1;
    use_fixed = 1'b0;
    stray = 1'b0;
    fixed_word = '0;
    ack_lat = 0;
    rdy_lat = 1;
    model_reset();
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_backpressure();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
